// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
// img_pkg
//   Shared state encoding and defaults for image-engine job controllers.
//   Revision: 1.0
// ============================================================================
package img_pkg;

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_launch    = 3'd1;
    localparam logic [2:0] c_st_wait_busy = 3'd2;
    localparam logic [2:0] c_st_wait_done = 3'd3;
    localparam logic [2:0] c_st_ack       = 3'd4;
    localparam logic [2:0] c_st_abort     = 3'd5;

    localparam int c_timeout_default = 4096;

    typedef enum logic [2:0] {
        IDLE      = c_st_idle,
        LAUNCH    = c_st_launch,
        WAIT_BUSY = c_st_wait_busy,
        WAIT_DONE = c_st_wait_done,
        ACK       = c_st_ack,
        ABORT     = c_st_abort
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/shrink_sched_if.sv
`default_nettype none
// ============================================================================
// shrink_sched_if
//   Requester handshake plus engine control bundle for the shrink scheduler.
//   Revision: 1.0
// ============================================================================
interface shrink_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] err;
    logic [IDW-1:0]  sel;
    logic            sel_valid;
    logic            busy;
    logic            eng_start;
    logic            eng_rst;
    logic            eng_done;

    // master: requesters and the engine; slave: the scheduler itself
    modport master (
        output req, eng_done,
        input  ack, err, sel, sel_valid, busy, eng_start, eng_rst
    );

    modport slave (
        input  req, eng_done,
        output ack, err, sel, sel_valid, busy, eng_start, eng_rst
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter
//   Round-robin priority search from a registered pointer; advance moves the
//   pointer just past the last served index.
//   Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          grant_valid
);

    logic [IW-1:0] r_ptr;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= wrap_idx(last, 1);
        end
    end

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant       = r_ptr;
        grant_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_idx(r_ptr, k)]) begin
                grant       = wrap_idx(r_ptr, k);
                grant_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shrink_sched.sv
`default_nettype none
// ============================================================================
// shrink_sched
//   Round-robin job scheduler for a single shrink engine with start/done
//   tracking, memory-port select and a watchdog abort.
//   Revision: 1.0
// ============================================================================
module shrink_sched
    import img_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = c_timeout_default,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic          clk,
    input  logic          rst,
    shrink_sched_if.slave bus
);

    localparam int               c_wdw     = $clog2(TIMEOUT + 1);
    localparam logic [c_wdw-1:0] c_wd_last = c_wdw'(TIMEOUT - 2);
    localparam logic [c_wdw-1:0] c_wd_max  = {c_wdw{1'b1}};

    sched_state_t    r_state;
    sched_state_t    w_next;
    logic [IDW-1:0]  r_sel;
    logic [c_wdw-1:0] r_wdog;
    logic            r_abort_2nd;
    logic            r_abort_q;
    logic [NREQ-1:0] r_ack;
    logic [NREQ-1:0] r_err;
    logic            r_sel_valid;
    logic            r_busy;
    logic            r_eng_start;

    logic [NREQ-1:0] w_sel_onehot;
    logic [IDW-1:0]  w_grant;
    logic            w_grant_valid;
    logic            w_advance;
    logic            w_waiting;
    logic            w_wd_hit;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (bus.req),
        .advance     (w_advance),
        .last        (r_sel),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    assign w_sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_sel;
    assign w_waiting    = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
    // Fires on the edge at which the watchdog reaches TIMEOUT-1.
    assign w_wd_hit     = w_waiting && (r_wdog == c_wd_last);

    always_comb begin
        w_next    = r_state;
        w_advance = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) w_next = LAUNCH;
            end
            LAUNCH: begin
                w_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (w_wd_hit)          w_next = ABORT;
                else if (!bus.eng_done) w_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (w_wd_hit)         w_next = ABORT;
                else if (bus.eng_done) w_next = ACK;
            end
            ACK: begin
                w_next    = IDLE;
                w_advance = 1'b1;
            end
            ABORT: begin
                if (r_abort_2nd) begin
                    w_next    = IDLE;
                    w_advance = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_wdog      <= '0;
            r_abort_2nd <= 1'b0;
            r_abort_q   <= 1'b0;
            r_ack       <= '0;
            r_err       <= '0;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_eng_start <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_grant_valid) r_sel <= w_grant;

            if (r_state == LAUNCH)
                r_wdog <= '0;
            else if (w_waiting && r_wdog != c_wd_max)
                r_wdog <= r_wdog + c_wdw'(1);

            r_abort_2nd <= (r_state == ABORT) && !r_abort_2nd;
            r_abort_q   <= (r_state == ABORT);
            r_ack       <= (r_state == ACK) ? w_sel_onehot : '0;
            r_err       <= (r_state == ABORT && !r_abort_2nd) ? w_sel_onehot : '0;
            r_eng_start <= (r_state == LAUNCH);
            r_sel_valid <= (r_state != IDLE);
            r_busy      <= (r_state != IDLE);
        end
    end

    assign bus.ack       = r_ack;
    assign bus.err       = r_err;
    assign bus.sel       = r_sel;
    assign bus.sel_valid = r_sel_valid;
    assign bus.busy      = r_busy;
    assign bus.eng_start = r_eng_start;
    // Engine stays in reset whenever this block is in reset.
    assign bus.eng_rst   = ~rst | r_abort_q;

endmodule
`default_nettype wire

// File: tb/tb_shrink_sched.sv
`default_nettype none
// Directed bench for shrink_sched: arbitration order, job timing, watchdog
// abort and mid-job reset against a simple engine stub.
module tb_shrink_sched;

    localparam int NREQ = 4;
    localparam int TMO  = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shrink_sched_if #(.NREQ(NREQ)) bif ();

    shrink_sched #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int checks = 0;
    int errors = 0;

    // Engine stub: done drops one cycle after start, rises 20 cycles later.
    logic hang = 1'b0;
    initial begin
        logic st, rs, running;
        int   cnt;
        running = 1'b0;
        cnt = 0;
        bif.eng_done = 1'b1;
        forever begin
            @(negedge clk);
            #2;
            st = bif.eng_start;
            rs = bif.eng_rst;
            @(posedge clk);
            #1;
            if (rs) begin
                running = 1'b0;
                bif.eng_done = 1'b1;
            end else if (st && !hang) begin
                running = 1'b1;
                cnt = 20;
                bif.eng_done = 1'b0;
            end else if (running) begin
                cnt--;
                if (cnt == 0) begin
                    running = 1'b0;
                    bif.eng_done = 1'b1;
                end
            end
        end
    end

    int         m_ack_k, m_err_k, m_ack_n, m_err_n, m_starts;
    int         m_rst_n, m_rst_k, m_idle_k, m_done_k;
    logic [3:0] m_ack_v, m_err_v;
    bit         m_sel_moved;

    task automatic nxt_cyc();
        @(negedge clk);
    endtask

    task automatic wait_start(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            nxt_cyc();
            if (bif.eng_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Observes a job from its start cycle (k=0); requesters drop req on ack/err.
    task automatic watch(input int maxc, input int churn_k, input logic [3:0] churn_req);
        logic [1:0] sel0;
        bit seen_low;
        sel0 = bif.sel;
        seen_low = 1'b0;
        m_ack_k = -1; m_err_k = -1; m_ack_n = 0; m_err_n = 0; m_starts = 0;
        m_rst_n = 0; m_rst_k = -1; m_idle_k = -1; m_done_k = -1;
        m_ack_v = '0; m_err_v = '0; m_sel_moved = 1'b0;
        for (int k = 1; k <= maxc; k++) begin
            nxt_cyc();
            if (!bif.eng_done) seen_low = 1'b1;
            else if (seen_low && m_done_k < 0) m_done_k = k;
            if (bif.eng_start) m_starts++;
            if (bif.eng_rst) begin
                m_rst_n++;
                if (m_rst_k < 0) m_rst_k = k;
            end
            if (m_ack_k < 0 && m_err_k < 0 && bif.sel != sel0) m_sel_moved = 1'b1;
            if (bif.ack != 4'b0) begin
                m_ack_n++;
                if (m_ack_k < 0) begin m_ack_k = k; m_ack_v = bif.ack; end
            end
            if (bif.err != 4'b0) begin
                m_err_n++;
                if (m_err_k < 0) begin m_err_k = k; m_err_v = bif.err; end
            end
            if (k == churn_k) bif.req = churn_req;
            bif.req = bif.req & ~bif.ack & ~bif.err;
            if (!bif.busy && (m_ack_k >= 0 || m_err_k >= 0)) begin
                m_idle_k = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bif.req = '0;
        repeat (3) nxt_cyc();
        checks++; if (bif.ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b want 0000", bif.ack); end
        checks++; if (bif.err !== 4'b0) begin errors++; $display("FAIL reset_err got %b want 0000", bif.err); end
        checks++; if (bif.sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", bif.sel); end
        checks++; if (bif.sel_valid !== 1'b0) begin errors++; $display("FAIL reset_sel_valid got %b want 0", bif.sel_valid); end
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bif.busy); end
        checks++; if (bif.eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng_start got %b want 0", bif.eng_start); end
        checks++; if (bif.eng_rst !== 1'b1) begin errors++; $display("FAIL reset_eng_rst got %b want 1", bif.eng_rst); end
        rst = 1'b1;
        nxt_cyc();
        checks++; if (bif.eng_rst !== 1'b0) begin errors++; $display("FAIL release_eng_rst got %b want 0", bif.eng_rst); end
        repeat (5) nxt_cyc();
        // eng_done sits high while idle and must not start anything
        checks++; if (bif.busy !== 1'b0 || bif.eng_start !== 1'b0) begin
            errors++; $display("FAIL idle_done_ignored got busy=%b start=%b want 0/0", bif.busy, bif.eng_start);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] order [6];
        logic [3:0] exp_ack;
        bit ok;
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3;
        order[4] = 2'd0; order[5] = 2'd2;
        bif.req = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            if (j == 4) bif.req = 4'b0101;
            wait_start(8, ok);
            checks++; if (!ok) begin errors++; $display("FAIL fair_start%0d got none want start", j); end
            checks++; if (bif.sel !== order[j]) begin errors++; $display("FAIL fair_sel%0d got %0d want %0d", j, bif.sel, order[j]); end
            watch(60, 0, 4'b0);
            exp_ack = 4'b0001 << order[j];
            checks++; if (m_ack_v !== exp_ack || m_ack_k != 23) begin
                errors++; $display("FAIL fair_ack%0d got %b@%0d want %b@23", j, m_ack_v, m_ack_k, exp_ack);
            end
        end
    endtask

    task automatic test_single();
        bif.req = 4'b0001;
        nxt_cyc();
        checks++; if (bif.sel !== 2'd0) begin errors++; $display("FAIL single_sel got %0d want 0", bif.sel); end
        checks++; if (bif.eng_start !== 1'b0 || bif.sel_valid !== 1'b0) begin
            errors++; $display("FAIL single_launch_lag got start=%b sv=%b want 0/0", bif.eng_start, bif.sel_valid);
        end
        nxt_cyc();
        checks++; if (bif.eng_start !== 1'b1 || bif.sel_valid !== 1'b1 || bif.busy !== 1'b1) begin
            errors++; $display("FAIL single_start got start=%b sv=%b busy=%b want 1/1/1", bif.eng_start, bif.sel_valid, bif.busy);
        end
        watch(60, 0, 4'b0);
        checks++; if (m_starts != 0) begin errors++; $display("FAIL single_extra_starts got %0d want 0", m_starts); end
        checks++; if (m_done_k != 21) begin errors++; $display("FAIL single_done_rise got %0d want 21", m_done_k); end
        checks++; if (m_ack_k != 23 || m_ack_v !== 4'b0001) begin
            errors++; $display("FAIL single_ack got %b@%0d want 0001@23", m_ack_v, m_ack_k);
        end
        checks++; if (m_ack_n != 1 || m_err_n != 0) begin
            errors++; $display("FAIL single_pulses got ack=%0d err=%0d want 1/0", m_ack_n, m_err_n);
        end
        checks++; if (m_idle_k != 24) begin errors++; $display("FAIL single_busy_low got %0d want 24", m_idle_k); end
        checks++; if (m_sel_moved) begin errors++; $display("FAIL single_sel_hold got moved want stable"); end
    endtask

    task automatic test_churn();
        bit ok;
        bif.req = 4'b0010;
        wait_start(8, ok);
        checks++; if (!ok || bif.sel !== 2'd1) begin errors++; $display("FAIL churn_sel got ok=%b sel=%0d want 1/1", ok, bif.sel); end
        watch(60, 10, 4'b1000);
        checks++; if (m_ack_v !== 4'b0010 || m_ack_k != 23) begin
            errors++; $display("FAIL churn_ack got %b@%0d want 0010@23", m_ack_v, m_ack_k);
        end
        checks++; if (m_sel_moved) begin errors++; $display("FAIL churn_sel_hold got moved want stable"); end
        wait_start(8, ok);
        checks++; if (!ok || bif.sel !== 2'd3) begin errors++; $display("FAIL churn_next got ok=%b sel=%0d want 1/3", ok, bif.sel); end
        watch(60, 0, 4'b0);
        checks++; if (m_ack_v !== 4'b1000) begin errors++; $display("FAIL churn_next_ack got %b want 1000", m_ack_v); end
    endtask

    task automatic test_timeout();
        bit ok;
        hang = 1'b1;
        bif.req = 4'b0100;
        wait_start(8, ok);
        checks++; if (!ok || bif.sel !== 2'd2) begin errors++; $display("FAIL tmo_sel got ok=%b sel=%0d want 1/2", ok, bif.sel); end
        watch(90, 0, 4'b0);
        checks++; if (m_err_k != 64 || m_err_v !== 4'b0100) begin
            errors++; $display("FAIL tmo_err got %b@%0d want 0100@64", m_err_v, m_err_k);
        end
        checks++; if (m_err_n != 1 || m_ack_n != 0) begin
            errors++; $display("FAIL tmo_pulses got err=%0d ack=%0d want 1/0", m_err_n, m_ack_n);
        end
        checks++; if (m_rst_n != 2 || m_rst_k != 64) begin
            errors++; $display("FAIL tmo_eng_rst got %0d cycles@%0d want 2@64", m_rst_n, m_rst_k);
        end
        checks++; if (m_idle_k != 66) begin errors++; $display("FAIL tmo_idle got %0d want 66", m_idle_k); end
        hang = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        int stray;
        bif.req = 4'b0010;
        wait_start(8, ok);
        checks++; if (!ok || bif.sel !== 2'd1) begin errors++; $display("FAIL rmid_sel got ok=%b sel=%0d want 1/1", ok, bif.sel); end
        repeat (10) nxt_cyc();
        rst = 1'b0;
        nxt_cyc();
        checks++; if (bif.busy !== 1'b0 || bif.sel_valid !== 1'b0 || bif.sel !== 2'd0) begin
            errors++; $display("FAIL rmid_state got busy=%b sv=%b sel=%0d want 0/0/0", bif.busy, bif.sel_valid, bif.sel);
        end
        checks++; if (bif.ack !== 4'b0 || bif.err !== 4'b0 || bif.eng_start !== 1'b0) begin
            errors++; $display("FAIL rmid_pulses got ack=%b err=%b start=%b want 0", bif.ack, bif.err, bif.eng_start);
        end
        checks++; if (bif.eng_rst !== 1'b1) begin errors++; $display("FAIL rmid_eng_rst got %b want 1", bif.eng_rst); end
        bif.req = '0;
        nxt_cyc();
        rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            nxt_cyc();
            if (bif.ack != 4'b0 || bif.err != 4'b0 || bif.busy) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rmid_stray got %0d want 0", stray); end
        bif.req = 4'b1001;
        wait_start(8, ok);
        checks++; if (!ok || bif.sel !== 2'd0) begin errors++; $display("FAIL rmid_ptr got ok=%b sel=%0d want 1/0", ok, bif.sel); end
        watch(60, 0, 4'b0);
        checks++; if (m_ack_v !== 4'b0001) begin errors++; $display("FAIL rmid_ack0 got %b want 0001", m_ack_v); end
        wait_start(8, ok);
        checks++; if (!ok || bif.sel !== 2'd3) begin errors++; $display("FAIL rmid_b2b got ok=%b sel=%0d want 1/3", ok, bif.sel); end
        watch(60, 0, 4'b0);
        checks++; if (m_ack_v !== 4'b1000 || m_ack_k != 23) begin
            errors++; $display("FAIL rmid_ack3 got %b@%0d want 1000@23", m_ack_v, m_ack_k);
        end
    endtask

    initial begin
        bif.req = '0;
        test_reset();
        test_fairness();
        test_single();
        test_churn();
        test_timeout();
        test_reset_mid_job();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shrink_sched.md
# shrink_sched

Job scheduler for the down-sampling engine (`shrink`). Shares a single engine between `NREQ` requesters (image producers or DMA channels) with round-robin arbitration. Launches each job with a one-cycle `start` pulse and tracks the engine's level-sensitive `done` through a full busy cycle. It also drives the memory-port select that routes the engine's `rd_adrr`/`wr_adrr` to the granted requester's buffers. A watchdog aborts hung jobs by resetting the engine.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; must be at least 2.
- `TIMEOUT`, 4096: maximum cycles from the `start` pulse to engine `done`. Must exceed the engine's worst-case frame time.
- `IDW`, `$clog2(NREQ)`: width of the select index.

Ports:
- `clk`  in  1  the single clock; all logic runs on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req`  in  NREQ  per-requester job request, level. Held until that requester sees `ack` or `err`.
- `ack`  out  NREQ  one-cycle completion pulse to the granted requester.
- `err`  out  NREQ  one-cycle timeout pulse to the granted requester. Mutually exclusive with `ack`.
- `sel`  out  IDW  granted requester index; drives the memory-port muxes.
- `sel_valid`  out  1  high while a job owns the engine, from LAUNCH through ACK/ABORT.
- `busy`  out  1  high in every state except IDLE.
- `eng_start`  out  1  start pulse to the engine.
- `eng_rst`  out  1  active-high engine reset.
- `eng_done`  in  1  engine `done` level. The engine holds it high while idle and drops it while running.

## Operation
State machine with six states:
- **IDLE**: if any `req` bit is set, latch the round-robin winner into `sel` and go to LAUNCH. Otherwise stay.
- **LAUNCH**: `eng_start`=1 for exactly one cycle. Clear the watchdog. Go to WAIT_BUSY.
- **WAIT_BUSY**: wait for `eng_done`=0, which proves the engine accepted the job. Then go to WAIT_DONE.
- **WAIT_DONE**: wait for `eng_done`=1. Then go to ACK.
- **ACK**: `ack[sel]`=1. Rotate the priority pointer to `sel+1` (mod NREQ). Go to IDLE.
- **ABORT**: entered from WAIT_BUSY or WAIT_DONE when the watchdog reaches `TIMEOUT-1`.
  - `err[sel]`=1 on the first ABORT cycle only.
  - `eng_rst`=1 for two cycles.
  - Rotate the pointer as in ACK, then go to IDLE.

Arbitration rules:
- Round-robin search starts at the pointer and wraps from index NREQ-1 to 0.
- After reset the pointer is 0, so requester 0 has the highest priority.

Watchdog:
- Counter width is `$clog2(TIMEOUT+1)`. It increments only in WAIT_BUSY and WAIT_DONE and saturates, never wrapping.
- The timeout check takes priority over a simultaneous `eng_done` transition in the same cycle.

Boundary conditions:
- `req` changes while busy are ignored. If the granted requester drops `req` mid-job, the job still completes and `ack` still pulses.
- A requester holding `req` high after its `ack` is re-served only after every other pending requester has been served.
- `sel` is held constant from LAUNCH until the cycle after ACK/ABORT; it never changes mid-job.
- `eng_done` being high in IDLE is ignored.

## Timing
- All outputs are registered, except `eng_rst`, which is `~rst | abort_q`. This keeps the engine in reset whenever this block is in reset.
- Values while `rst`=0: state IDLE, `ack`=0, `err`=0, `sel`=0, `sel_valid`=0, `busy`=0, `eng_start`=0, pointer 0, watchdog 0, `eng_rst`=1.
- `req` is sampled in IDLE at edge N. `eng_start` and `sel_valid` go high at N+1.
- `eng_done` rising edge sampled in WAIT_DONE at edge M gives `ack` high at M+1 and `busy` low at M+2.
- Back-to-back jobs: there is one IDLE cycle between an ACK and the next LAUNCH.
- Reset asserted mid-job: the block returns to IDLE on the next edge, with no `ack` or `err`, and the engine is reset with it.

## Structure
- Package `img_pkg` holds the state encoding (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, ACK, ABORT as 3-bit localparams) and the `TIMEOUT` default, shared with future image-processing controllers.
- Sub-module `rr_arbiter`: combinational priority search plus a registered pointer with an `advance` input. It is reusable by later multi-engine schedulers.

## Test plan
- **Single job:** reset, then `req`=4'b0001. Engine stub drops `done` 1 cycle after `start` and raises it 20 cycles later. Expect `sel`=0, exactly one `eng_start`, and `ack`=4'b0001 one cycle after `done` rises.
- **Fairness:** `req`=4'b1111 held, with each requester dropping `req` on its own `ack`. Expect grant order 0,1,2,3. Then re-raise `req[0]` and `req[2]` and expect order 0,2.
- **Timeout:** `TIMEOUT`=64 and the engine never drops `done`. Expect `err[sel]` exactly 64 cycles after the `start` cycle, `eng_rst` high for 2 cycles, no `ack`, and a return to IDLE.
- **Mid-job request churn:** `req[1]` drops in WAIT_DONE while `req[3]` rises. Expect `ack[1]` still pulses and `sel` does not change until ACK. The next grant is requester 3.
- **Reset mid-job:** assert `rst`=0 in WAIT_DONE. Expect all outputs at their reset values on the next edge, `eng_rst`=1, and no stray `ack` or `err` after `rst` releases.
